// File: rtl/vga_timing_pkg.sv
// Shared timing constants, counter/colour types and small helpers for the
// 640x480@60 Hz text display.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [2:0]       rgb_t;

    localparam int DIV_DEFAULT    = 4;
    localparam int H_DISP_DEFAULT = 640;
    localparam int H_FP_DEFAULT   = 16;
    localparam int H_SYNC_DEFAULT = 96;
    localparam int H_BP_DEFAULT   = 48;
    localparam int V_DISP_DEFAULT = 480;
    localparam int V_FP_DEFAULT   = 10;
    localparam int V_SYNC_DEFAULT = 2;
    localparam int V_BP_DEFAULT   = 33;

    localparam int H_TOTAL = H_DISP_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
    localparam int V_TOTAL = V_DISP_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

    localparam int H_SYNC_START = H_DISP_DEFAULT + H_FP_DEFAULT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEFAULT - 1;
    localparam int V_SYNC_START = V_DISP_DEFAULT + V_FP_DEFAULT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEFAULT - 1;

    localparam rgb_t BLACK = 3'b000;
    localparam rgb_t WHITE = 3'b111;
    localparam rgb_t BLUE  = 3'b001;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing/pixel bundle between the sync generator and the text generator / VGA pins.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic p_tick;
    cnt_t pixel_x;
    cnt_t pixel_y;
    logic video_on;
    logic hsync;
    logic vsync;
    logic frame_start;
    rgb_t rgb_in;
    rgb_t rgb_out;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, rgb_out,
        input  rgb_in
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, rgb_out,
        output rgb_in
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divides CLK by DIV and flags the last cycle of every pixel slot.
module pixel_tick_gen #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic p_tick
);

    localparam int             DW   = $clog2(DIV);
    localparam logic [DW-1:0]  LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (div_cnt >= LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel timing generator: pixel enable, coordinates, registered active-low
// syncs and the blanked RGB register feeding the VGA pins.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV    = DIV_DEFAULT,
    parameter int H_DISP = H_DISP_DEFAULT,
    parameter int H_FP   = H_FP_DEFAULT,
    parameter int H_SYNC = H_SYNC_DEFAULT,
    parameter int H_BP   = H_BP_DEFAULT,
    parameter int V_DISP = V_DISP_DEFAULT,
    parameter int V_FP   = V_FP_DEFAULT,
    parameter int V_SYNC = V_SYNC_DEFAULT,
    parameter int V_BP   = V_BP_DEFAULT
) (
    input  logic           CLK,
    input  logic           RESET_N,
    vga_sync_gen_if.master vga
);

    localparam int   H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
    localparam cnt_t H_SS   = cnt_t'(H_DISP + H_FP);
    localparam cnt_t H_SE   = cnt_t'(H_DISP + H_FP + H_SYNC - 1);
    localparam cnt_t V_SS   = cnt_t'(V_DISP + V_FP);
    localparam cnt_t V_SE   = cnt_t'(V_DISP + V_FP + V_SYNC - 1);

    logic p_tick;
    cnt_t h_cnt, v_cnt;
    cnt_t h_nxt, v_nxt;
    logic frame_wrap;
    logic video_on;
    logic hsync_q, vsync_q, frame_start_q;
    rgb_t rgb_q;

    pixel_tick_gen #(.DIV(DIV)) u_tick (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .p_tick  (p_tick)
    );

    // Out-of-range counts (never reached normally) also wrap to 0.
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (p_tick) begin
            if (h_cnt >= H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt >= V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
            end
        end
    end

    assign frame_wrap = p_tick && (h_cnt >= H_LAST) && (v_cnt >= V_LAST);
    assign video_on   = (h_cnt < cnt_t'(H_DISP)) && (v_cnt < cnt_t'(V_DISP));

    // Syncs come from the next-state counters so they move on the same edge
    // as pixel_x/pixel_y; RGB is captured in the last cycle of the pixel slot.
    // NOTE: this block holds only control state (no memories), so every register is reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= BLACK;
        end else begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            hsync_q       <= !in_window(h_nxt, H_SS, H_SE);
            vsync_q       <= !in_window(v_nxt, V_SS, V_SE);
            frame_start_q <= frame_wrap;
            if (p_tick) begin
                rgb_q <= video_on ? vga.rgb_in : BLACK;
            end
        end
    end

    assign vga.p_tick      = p_tick;
    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.video_on    = video_on;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_start_q;
    assign vga.rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three configurations (default DIV=4,
// default DIV=2, a small DIV=4 raster) checked every cycle against a closed-form model.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int div, hd, hfp, hs, hbp, vd, vfp, vs, vbp;
    } cfg_t;

    typedef struct {
        logic p_tick;
        int   x, y;
        logic von, hs, vs, fs;
        rgb_t rgb;
    } e_t;

    logic clk;
    logic rst_n;
    rgb_t rgb_drv;
    int   cur_phase;
    int   checks;
    int   errors;
    int   k [3];
    rgb_t rgb_exp [3];
    e_t   sb0 [$];
    e_t   sb1 [$];
    e_t   sb2 [$];
    int   hs_low_a, hs_low_b, fs_c;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    assign if_a.rgb_in = rgb_drv;
    assign if_b.rgb_in = rgb_drv;
    assign if_c.rgb_in = rgb_drv;

    vga_sync_gen #(.DIV(4)) dut_a (.CLK(clk), .RESET_N(rst_n), .vga(if_a.master));
    vga_sync_gen #(.DIV(2)) dut_b (.CLK(clk), .RESET_N(rst_n), .vga(if_b.master));
    vga_sync_gen #(
        .DIV(4), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_c (.CLK(clk), .RESET_N(rst_n), .vga(if_c.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cfg_t get_cfg(int i);
        cfg_t c;
        c = '{div: 4, hd: 640, hfp: 16, hs: 96, hbp: 48, vd: 480, vfp: 10, vs: 2, vbp: 33};
        if (i == 1) c.div = 2;
        if (i == 2) c = '{div: 4, hd: 8, hfp: 2, hs: 3, hbp: 2, vd: 4, vfp: 1, vs: 2, vbp: 1};
        return c;
    endfunction

    // Expected outputs after k clock edges since reset was released.
    function automatic e_t model(cfg_t c, int kk, rgb_t rgb);
        e_t m;
        int ht, vt, n, h, v;
        ht = c.hd + c.hfp + c.hs + c.hbp;
        vt = c.vd + c.vfp + c.vs + c.vbp;
        n  = kk / c.div;
        h  = n % ht;
        v  = (n / ht) % vt;
        m.p_tick = ((kk % c.div) == c.div - 1);
        m.x      = h;
        m.y      = v;
        m.von    = (h < c.hd) && (v < c.vd);
        m.hs     = !((h >= c.hd + c.hfp) && (h < c.hd + c.hfp + c.hs));
        m.vs     = !((v >= c.vd + c.vfp) && (v < c.vd + c.vfp + c.vs));
        m.fs     = (kk > 0) && ((kk % c.div) == 0) && ((n % (ht * vt)) == 0);
        m.rgb    = rgb;
        return m;
    endfunction

    function automatic e_t pack(logic pt, cnt_t x, cnt_t y, logic von, logic hs,
                                logic vs, logic fs, rgb_t rgb);
        e_t a;
        a.p_tick = pt;
        a.x      = int'(x);
        a.y      = int'(y);
        a.von    = von;
        a.hs     = hs;
        a.vs     = vs;
        a.fs     = fs;
        a.rgb    = rgb;
        return a;
    endfunction

    function automatic e_t actual(int i);
        if (i == 0)
            return pack(if_a.p_tick, if_a.pixel_x, if_a.pixel_y, if_a.video_on,
                        if_a.hsync, if_a.vsync, if_a.frame_start, if_a.rgb_out);
        else if (i == 1)
            return pack(if_b.p_tick, if_b.pixel_x, if_b.pixel_y, if_b.video_on,
                        if_b.hsync, if_b.vsync, if_b.frame_start, if_b.rgb_out);
        else
            return pack(if_c.p_tick, if_c.pixel_x, if_c.pixel_y, if_c.video_on,
                        if_c.hsync, if_c.vsync, if_c.frame_start, if_c.rgb_out);
    endfunction

    task automatic check(input int i, input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, i, $time, act, expv);
        end
    endtask

    task automatic compare(input int i, input e_t a, input e_t e);
        check(i, "p_tick",      32'(a.p_tick), 32'(e.p_tick));
        check(i, "pixel_x",     a.x,           e.x);
        check(i, "pixel_y",     a.y,           e.y);
        check(i, "video_on",    32'(a.von),    32'(e.von));
        check(i, "hsync",       32'(a.hs),     32'(e.hs));
        check(i, "vsync",       32'(a.vs),     32'(e.vs));
        check(i, "frame_start", 32'(a.fs),     32'(e.fs));
        check(i, "rgb_out",     32'(a.rgb),    32'(e.rgb));
    endtask

    task automatic push(input int i, input e_t e);
        if (i == 0) sb0.push_back(e);
        else if (i == 1) sb1.push_back(e);
        else sb2.push_back(e);
    endtask

    // Apply inputs for the next edge, then queue the state expected after it.
    task automatic step(input logic rst_v, input rgb_t rgb_v, input int ph);
        e_t   pre;
        cfg_t c;
        rst_n   = rst_v;
        rgb_drv = rgb_v;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            c = get_cfg(i);
            if (!rst_v) begin
                k[i]       = 0;
                rgb_exp[i] = BLACK;
            end else begin
                pre = model(c, k[i], rgb_exp[i]);
                if (pre.p_tick) rgb_exp[i] = pre.von ? rgb_v : BLACK;
                k[i]++;
            end
            push(i, model(c, k[i], rgb_exp[i]));
        end
        cur_phase = ph;
    endtask

    // Monitor: pops one expectation per configuration on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb0.size() > 0) compare(0, actual(0), sb0.pop_front());
            if (sb1.size() > 0) compare(1, actual(1), sb1.pop_front());
            if (sb2.size() > 0) compare(2, actual(2), sb2.pop_front());
            if (cur_phase == 1) begin
                if (if_a.hsync == 1'b0) hs_low_a++;
                if (if_b.hsync == 1'b0) hs_low_b++;
                if (if_c.frame_start) fs_c++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rgb_t tbl [5];
        tbl       = '{WHITE, BLACK, 3'b010, BLUE, 3'b101};
        checks    = 0;
        errors    = 0;
        hs_low_a  = 0;
        hs_low_b  = 0;
        fs_c      = 0;
        cur_phase = 0;
        rst_n     = 1'b0;
        rgb_drv   = BLUE;

        repeat (3) step(1'b0, BLUE, 0);
        // One full default line at DIV=4, two at DIV=2, six small frames.
        repeat (3300) step(1'b1, BLUE, 1);
        repeat (300) step(1'b1, 3'b110, 2);
        for (int j = 0; j < 200; j++) step(1'b1, tbl[j % 5], 2);
        // Single-cycle reset in the middle of a frame, then restart.
        step(1'b0, BLUE, 3);
        repeat (700) step(1'b1, BLUE, 3);

        @(negedge clk);
        @(negedge clk);
        check(0, "hsync_low_clk_line0", hs_low_a, 384);
        check(1, "hsync_low_clk_two_lines", hs_low_b, 384);
        check(2, "frame_start_pulses", fs_c, 6);
        check(0, "scoreboard_drain", sb0.size(), 0);
        check(1, "scoreboard_drain", sb1.size(), 0);
        check(2, "scoreboard_drain", sb2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
